alien_hit_detector: RTL and testbench
=====================================

Name: alien_hit_detector

Overview:
Sits directly upstream of the alien formation block and produces its kill_matrix input. It watches the VGA scan for overlap between the player-bullet pixel and each live alien's graphics bit, and latches at most one hit per frame. At frame end it commits that hit as a one-cycle kill pulse, a bullet-hit pulse, a score update and a wave-cleared check.

Parameters:
NUM_ROWS, 2, alien rows; must match the formation.
NUM_COLUMNS, 4, alien columns; must match the formation.
BASE_POINTS, 10, points per kill in the bottom row; row r scores BASE_POINTS*(NUM_ROWS-r).
SCORE_WIDTH, 16, score counter width.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
scan_valid  input  1  scan is inside the visible area
frame_end  input  1  one-cycle pulse at the last visible pixel of a frame
bullet_pixel  input  1  player bullet drawn at the current scan position
graphics_matrix  input  [NUM_ROWS-1:0][NUM_COLUMNS-1:0]  per-alien pixel-hit bits from the formation
alive_matrix  input  [NUM_ROWS-1:0][NUM_COLUMNS-1:0]  per-alien alive bits from the formation
wave_ack  input  1  clears wave_cleared
kill_matrix  output  [NUM_ROWS-1:0][NUM_COLUMNS-1:0]  one-hot kill pulse to the formation
bullet_hit  output  1  one-cycle pulse; the bullet block retires the bullet
score  output  SCORE_WIDTH  accumulated score
aliens_remaining  output  $clog2(NUM_ROWS*NUM_COLUMNS+1)  popcount of alive_matrix, registered
wave_cleared  output  1  sticky flag: all aliens are dead

Behaviour:
- Clock and reset: a single clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=SCAN, kill_matrix=0, bullet_hit=0, score=0, aliens_remaining=NUM_ROWS*NUM_COLUMNS, wave_cleared=0, hit latch empty. Reset asserted in any state aborts a pending hit with no kill and no score.
- Hit candidate vector = graphics_matrix & alive_matrix & {bullet_pixel & scan_valid}.
- If several candidates are set in one cycle, pick the lowest flat index, row*NUM_COLUMNS+column, with row 0 first.
- State machine:
  - SCAN: while the hit latch is empty, a nonzero candidate vector stores the one-hot index and row number and sets the latch; later candidates in the same frame are ignored. On frame_end: go to COMMIT if the latch is set (including a hit latched in that same cycle), otherwise stay in SCAN.
  - COMMIT (1 cycle): kill_matrix = latched one-hot, ANDed with the current alive_matrix; bullet_hit=1 only if that AND is nonzero. score <= score + BASE_POINTS*(NUM_ROWS-row), saturating at all-ones, only if the AND is nonzero. Clear the latch. Next state is WAIT_CLEAR.
  - WAIT_CLEAR (1 cycle): the formation has applied the kill on the COMMIT edge. Register aliens_remaining <= popcount(alive_matrix). If the popcount is 0, set wave_cleared. Next state is SCAN.
- kill_matrix and bullet_hit are zero in every state except COMMIT, so each asserts for exactly one cycle.
- Latency: frame_end is at cycle N. kill_matrix and bullet_hit are high in cycle N+1. score is visible at N+2. aliens_remaining and wave_cleared are visible at N+3.
- frame_end during COMMIT or WAIT_CLEAR is ignored. Candidates during those states are ignored and do not latch.
- wave_ack clears wave_cleared. If wave_ack and the set condition occur in the same cycle, set wins.
- aliens_remaining also refreshes every SCAN cycle from alive_matrix, so a formation-level reset or refill is tracked.
- Score arithmetic uses a SCORE_WIDTH+1 sum. If the carry is set, the result is all-ones.

Decomposition:
- Shared package (game_pkg):
  - hit_state_t enum with states SCAN, COMMIT and WAIT_CLEAR.
  - Alien grid dimension constants.
  - SCORE_WIDTH.
- Sub-module priority_onehot: lowest-index one-hot encoder that also returns the row index; parameterised by vector width.
- The popcount stays inline.

Test Plan:
1. Reset, then a clean frame with no bullet overlap and one frame_end: kill_matrix stays 0, score=0, aliens_remaining=8.
2. Overlap on alien [1][2] with alive=all-ones, then frame_end: kill_matrix=8'b0100_0000 (row1 col2) for exactly one cycle; bullet_hit pulses; score=10. With the formation model, aliens_remaining=7.
3. Same cycle overlap of [0][3] and [1][0]: only [0][3] is killed and score=+20. A second overlap later in the same frame on [1][1] is ignored.
4. Overlap coincides with the frame_end cycle: the kill is committed at N+1.
5. The latched alien dies via another path before COMMIT: kill_matrix=0, bullet_hit=0, score unchanged.
6. Kill the last alive alien: wave_cleared=1 at N+3 and stays high until wave_ack. Preload score=16'hFFF5 and kill a row-0 alien: score=16'hFFFF (saturated). Assert rst during COMMIT: no pulse, and all outputs return to their reset values.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and grid constants for the alien hit detector slice.
package game_pkg;

   localparam int NUM_ROWS    = 2;
   localparam int NUM_COLUMNS = 4;
   localparam int NUM_ALIENS  = NUM_ROWS * NUM_COLUMNS;
   localparam int BASE_POINTS = 10;
   localparam int SCORE_WIDTH = 16;

   typedef enum logic [1:0] {
      SCAN       = 2'd0,
      COMMIT     = 2'd1,
      WAIT_CLEAR = 2'd2
   } hit_state_t;

endpackage

// File: rtl/alien_hit_detector_if.sv
// Scan-side inputs and formation/score outputs of the hit detector.
interface alien_hit_detector_if #(
   parameter int NUM_ROWS    = game_pkg::NUM_ROWS,
   parameter int NUM_COLUMNS = game_pkg::NUM_COLUMNS,
   parameter int SCORE_WIDTH = game_pkg::SCORE_WIDTH
);
   localparam int CNT_W = $clog2(NUM_ROWS * NUM_COLUMNS + 1);

   logic                                  scan_valid;
   logic                                  frame_end;
   logic                                  bullet_pixel;
   logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0]  graphics_matrix;
   logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0]  alive_matrix;
   logic                                  wave_ack;
   logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0]  kill_matrix;
   logic                                  bullet_hit;
   logic [SCORE_WIDTH-1:0]                score;
   logic [CNT_W-1:0]                      aliens_remaining;
   logic                                  wave_cleared;

   modport master (
      output scan_valid, frame_end, bullet_pixel, graphics_matrix, alive_matrix, wave_ack,
      input  kill_matrix, bullet_hit, score, aliens_remaining, wave_cleared
   );

   modport slave (
      input  scan_valid, frame_end, bullet_pixel, graphics_matrix, alive_matrix, wave_ack,
      output kill_matrix, bullet_hit, score, aliens_remaining, wave_cleared
   );
endinterface

// File: rtl/alien_hit_detector_priority_onehot.sv
// Lowest-index one-hot pick over a flat alien vector, plus the row of the pick.
module priority_onehot #(
   parameter int WIDTH = 8,
   parameter int COLS  = 4,
   parameter int ROW_W = 1
) (
   input  logic [WIDTH-1:0] vec_i,
   output logic [WIDTH-1:0] onehot_o,
   output logic [ROW_W-1:0] row_o,
   output logic             any_o
);
   logic found;

   always_comb begin
      onehot_o = '0;
      row_o    = '0;
      found    = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (vec_i[i] && !found) begin
            onehot_o[i] = 1'b1;
            row_o       = ROW_W'(i / COLS);
            found       = 1'b1;
         end
      end
      any_o = found;
   end
endmodule

// File: rtl/alien_hit_detector.sv
// Latches the first bullet/alien overlap of a frame and commits it at frame end
// as a one-cycle kill, a saturating score update and a wave-cleared check.
module alien_hit_detector #(
   parameter int NUM_ROWS    = game_pkg::NUM_ROWS,
   parameter int NUM_COLUMNS = game_pkg::NUM_COLUMNS,
   parameter int BASE_POINTS = game_pkg::BASE_POINTS,
   parameter int SCORE_WIDTH = game_pkg::SCORE_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   alien_hit_detector_if.slave  bus
);
   import game_pkg::*;

   localparam int N     = NUM_ROWS * NUM_COLUMNS;
   localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int CNT_W = $clog2(N + 1);

   hit_state_t             state_q;
   logic                   latch_vld_q;
   logic [N-1:0]           latch_oh_q;
   logic [ROW_W-1:0]       latch_row_q;
   logic [SCORE_WIDTH-1:0] score_q;
   logic [SCORE_WIDTH-1:0] score_d;
   logic [CNT_W-1:0]       remaining_q;
   logic [CNT_W-1:0]       remaining_d;
   logic                   wave_cleared_q;

   logic [N-1:0]           graphics;
   logic [N-1:0]           alive;
   logic [N-1:0]           cand;
   logic [N-1:0]           pick_oh;
   logic [ROW_W-1:0]       pick_row;
   logic                   pick_any;
   logic [N-1:0]           kill_d;
   logic [SCORE_WIDTH-1:0] points;
   logic [SCORE_WIDTH:0]   sum;

   assign graphics = bus.graphics_matrix;
   assign alive    = bus.alive_matrix;
   assign cand     = graphics & alive & {N{bus.bullet_pixel & bus.scan_valid}};

   priority_onehot #(
      .WIDTH (N),
      .COLS  (NUM_COLUMNS),
      .ROW_W (ROW_W)
   ) u_pick (
      .vec_i    (cand),
      .onehot_o (pick_oh),
      .row_o    (pick_row),
      .any_o    (pick_any)
   );

   // Masked by the live alive bits so an alien killed elsewhere since latching is not re-killed.
   assign kill_d = (state_q == COMMIT && !rst) ? (latch_oh_q & alive) : '0;

   assign points  = SCORE_WIDTH'(BASE_POINTS * (NUM_ROWS - int'(latch_row_q)));
   assign sum     = {1'b0, score_q} + {1'b0, points};
   assign score_d = sum[SCORE_WIDTH] ? '1 : sum[SCORE_WIDTH-1:0];

   always_comb begin
      remaining_d = '0;
      for (int i = 0; i < N; i++) begin
         remaining_d = remaining_d + CNT_W'(alive[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= SCAN;
         latch_vld_q    <= 1'b0;
         latch_oh_q     <= '0;
         latch_row_q    <= '0;
         score_q        <= '0;
         remaining_q    <= CNT_W'(N);
         wave_cleared_q <= 1'b0;
      end else begin
         if (bus.wave_ack) begin
            wave_cleared_q <= 1'b0;
         end
         case (state_q)
            SCAN: begin
               remaining_q <= remaining_d;
               if (!latch_vld_q && pick_any) begin
                  latch_vld_q <= 1'b1;
                  latch_oh_q  <= pick_oh;
                  latch_row_q <= pick_row;
               end
               if (bus.frame_end && (latch_vld_q || pick_any)) begin
                  state_q <= COMMIT;
               end
            end
            COMMIT: begin
               if (|kill_d) begin
                  score_q <= score_d;
               end
               latch_vld_q <= 1'b0;
               state_q     <= WAIT_CLEAR;
            end
            WAIT_CLEAR: begin
               // Formation applied the kill on the previous edge, so alive is current here.
               remaining_q <= remaining_d;
               if (remaining_d == '0) begin
                  wave_cleared_q <= 1'b1;
               end
               state_q <= SCAN;
            end
            default: begin
               state_q <= SCAN;
            end
         endcase
      end
   end

   assign bus.kill_matrix      = kill_d;
   assign bus.bullet_hit       = |kill_d;
   assign bus.score            = score_q;
   assign bus.aliens_remaining = remaining_q;
   assign bus.wave_cleared     = wave_cleared_q;
endmodule

// File: tb/tb_alien_hit_detector.sv
// Directed bench for alien_hit_detector: per-cycle vector table plus hand sequences,
// with a small formation model that clears alive bits on each kill pulse.
module tb_alien_hit_detector;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alien_hit_detector_if #(.NUM_ROWS(2), .NUM_COLUMNS(4), .SCORE_WIDTH(16)) bus ();

   alien_hit_detector #(
      .NUM_ROWS    (2),
      .NUM_COLUMNS (4),
      .BASE_POINTS (10),
      .SCORE_WIDTH (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic       load_req;
   logic [7:0] load_val;
   logic [7:0] alive_m;

   always @(posedge clk) begin
      if (rst)           alive_m <= 8'hFF;
      else if (load_req) alive_m <= load_val;
      else               alive_m <= alive_m & ~8'(bus.kill_matrix);
   end
   assign bus.alive_matrix = alive_m;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        sv;
      logic        bp;
      logic        fe;
      logic        ack;
      logic [7:0]  g;
      logic [7:0]  ek;
      logic        eh;
      logic [15:0] es;
      logic [3:0]  er;
      logic        ew;
   } vec_t;

   vec_t tbl [20];

   function automatic vec_t mk(input logic sv, input logic bp, input logic fe, input logic ack,
                               input logic [7:0] g, input logic [7:0] ek, input logic eh,
                               input logic [15:0] es, input logic [3:0] er, input logic ew);
      vec_t v;
      v.sv = sv; v.bp = bp; v.fe = fe; v.ack = ack; v.g = g;
      v.ek = ek; v.eh = eh; v.es = es; v.er = er; v.ew = ew;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] k, input logic h,
                          input logic [15:0] s, input logic [3:0] r, input logic w);
      chk($sformatf("%s.kill", tag),  32'(bus.kill_matrix),      32'(k));
      chk($sformatf("%s.hit", tag),   32'(bus.bullet_hit),       32'(h));
      chk($sformatf("%s.score", tag), 32'(bus.score),            32'(s));
      chk($sformatf("%s.rem", tag),   32'(bus.aliens_remaining), 32'(r));
      chk($sformatf("%s.wave", tag),  32'(bus.wave_cleared),     32'(w));
   endtask

   // Drive one cycle's inputs, then wait to the sampling edge.
   task automatic apply(input logic sv, input logic bp, input logic fe,
                        input logic [7:0] g, input logic ack);
      bus.scan_valid      = sv;
      bus.bullet_pixel    = bp;
      bus.frame_end       = fe;
      bus.graphics_matrix = g;
      bus.wave_ack        = ack;
      @(negedge clk);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alive(input logic [7:0] v);
      load_val = v;
      load_req = 1'b1;
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      next();
      load_req = 1'b0;
   endtask

   initial begin
      tbl[0]  = mk(1,1,0,0, 8'h00, 8'h00,0,16'd0, 4'd8,0);
      tbl[1]  = mk(1,0,1,0, 8'hFF, 8'h00,0,16'd0, 4'd8,0);
      tbl[2]  = mk(0,0,0,0, 8'h00, 8'h00,0,16'd0, 4'd8,0);
      tbl[3]  = mk(1,1,0,0, 8'h40, 8'h00,0,16'd0, 4'd8,0);
      tbl[4]  = mk(1,0,1,0, 8'h00, 8'h00,0,16'd0, 4'd8,0);
      tbl[5]  = mk(0,0,0,0, 8'h00, 8'h40,1,16'd0, 4'd8,0);
      tbl[6]  = mk(0,0,0,0, 8'h00, 8'h00,0,16'd10,4'd8,0);
      tbl[7]  = mk(0,0,0,0, 8'h00, 8'h00,0,16'd10,4'd7,0);
      tbl[8]  = mk(1,1,0,0, 8'h18, 8'h00,0,16'd10,4'd7,0);
      tbl[9]  = mk(1,1,0,0, 8'h20, 8'h00,0,16'd10,4'd7,0);
      tbl[10] = mk(1,0,1,0, 8'h00, 8'h00,0,16'd10,4'd7,0);
      tbl[11] = mk(0,0,0,0, 8'h00, 8'h08,1,16'd10,4'd7,0);
      tbl[12] = mk(0,0,0,0, 8'h00, 8'h00,0,16'd30,4'd7,0);
      tbl[13] = mk(0,0,0,0, 8'h00, 8'h00,0,16'd30,4'd6,0);
      tbl[14] = mk(1,1,1,0, 8'h01, 8'h00,0,16'd30,4'd6,0);
      tbl[15] = mk(1,1,1,0, 8'h02, 8'h01,1,16'd30,4'd6,0);
      tbl[16] = mk(1,1,1,0, 8'h02, 8'h00,0,16'd50,4'd6,0);
      tbl[17] = mk(0,0,0,0, 8'h00, 8'h00,0,16'd50,4'd5,0);
      tbl[18] = mk(1,0,1,0, 8'h00, 8'h00,0,16'd50,4'd5,0);
      tbl[19] = mk(0,0,0,0, 8'h00, 8'h00,0,16'd50,4'd5,0);

      rst      = 1'b1;
      load_req = 1'b0;
      load_val = 8'h00;
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk_all("reset", 8'h00, 1'b0, 16'd0, 4'd8, 1'b0);
      next();
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         apply(tbl[i].sv, tbl[i].bp, tbl[i].fe, tbl[i].g, tbl[i].ack);
         chk_all($sformatf("v%0d", i), tbl[i].ek, tbl[i].eh, tbl[i].es, tbl[i].er, tbl[i].ew);
         next();
      end

      // Latched alien dies through another path before commit.
      apply(1'b1, 1'b1, 1'b0, 8'h80, 1'b0); next();
      set_alive(8'h36);
      apply(1'b1, 1'b0, 1'b1, 8'h00, 1'b0); next();
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("dead_latch.kill", 32'(bus.kill_matrix), 32'h0);
      chk("dead_latch.hit",  32'(bus.bullet_hit),  32'h0);
      next();
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("dead_latch.score", 32'(bus.score), 32'd50);
      next();
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("dead_latch.rem", 32'(bus.aliens_remaining), 32'd4);
      next();

      // Last alien killed: wave_cleared at N+3, sticky until acknowledged.
      set_alive(8'h10);
      apply(1'b1, 1'b1, 1'b1, 8'h10, 1'b0); next();
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("last.kill", 32'(bus.kill_matrix), 32'h10);
      chk("last.hit",  32'(bus.bullet_hit),  32'h1);
      next();
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("last.score", 32'(bus.score), 32'd60);
      chk("last.wave_n2", 32'(bus.wave_cleared), 32'h0);
      next();
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("last.wave_n3", 32'(bus.wave_cleared), 32'h1);
      chk("last.rem", 32'(bus.aliens_remaining), 32'd0);
      next();
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
         chk($sformatf("sticky%0d", i), 32'(bus.wave_cleared), 32'h1);
         next();
      end
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); next();
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("ack.wave", 32'(bus.wave_cleared), 32'h0);
      next();

      // Set condition and wave_ack in the same cycle: set wins.
      set_alive(8'h01);
      apply(1'b1, 1'b1, 1'b0, 8'h01, 1'b0); next();
      set_alive(8'h00);
      apply(1'b0, 1'b0, 1'b1, 8'h00, 1'b0); next();
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("setwin.kill", 32'(bus.kill_matrix), 32'h0);
      next();
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); next();
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("setwin.wave",  32'(bus.wave_cleared), 32'h1);
      chk("setwin.score", 32'(bus.score), 32'd60);
      next();

      // Saturation: 3276 row-0 kills reach 16'hFFF0, the next one saturates.
      rst = 1'b1;
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0); next();
      rst      = 1'b0;
      load_val = 8'hFF;
      load_req = 1'b1;
      for (int i = 0; i < 3276; i++) begin
         apply(1'b1, 1'b1, 1'b1, 8'h01, 1'b0); next();
         apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0); next();
         apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0); next();
      end
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("sat.pre", 32'(bus.score), 32'hFFF0);
      next();
      for (int k = 0; k < 2; k++) begin
         apply(1'b1, 1'b1, 1'b1, 8'h01, 1'b0); next();
         apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0); next();
         apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
         chk($sformatf("sat.post%0d", k), 32'(bus.score), 32'hFFFF);
         next();
      end

      // Reset during COMMIT aborts the pending hit.
      apply(1'b1, 1'b1, 1'b1, 8'h01, 1'b0); next();
      rst = 1'b1;
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("rstc.kill", 32'(bus.kill_matrix), 32'h0);
      chk("rstc.hit",  32'(bus.bullet_hit),  32'h0);
      next();
      rst = 1'b0;
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk_all("rstc.after", 8'h00, 1'b0, 16'd0, 4'd8, 1'b0);
      next();
      apply(1'b1, 1'b0, 1'b1, 8'h00, 1'b0); next();
      apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("rstc.no_stale", 32'(bus.kill_matrix), 32'h0);
      next();
      load_req = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
